// File: rtl/dps_strap_pkg.sv
// Shared types for the DPS strap controller: FSM states, strap pair and fallback value.
// The WAIT_IDLE state exists only when DPS_STRAP_RESAMPLE_EN is defined.
package dps_strap_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StLocked
`ifdef DPS_STRAP_RESAMPLE_EN
        ,
        StWaitIdle
`endif
    } state_e;

    typedef struct packed {
        logic jtag_spi_n;
        logic boot;
    } strap_t;

    // Selected when debounce times out: SPI on the DPS pads, boot strap low.
    localparam strap_t StrapFallback = '{jtag_spi_n: 1'b0, boot: 1'b0};

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for asynchronous inputs.
module prim_flop_2sync #(
    parameter int unsigned      Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage1_q;
    logic [Width-1:0] stage2_q;

    // Two back-to-back flops give metastability a full cycle to resolve.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage1_q <= ResetValue;
            stage2_q <= ResetValue;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/dps_strap_ctrl.sv
// DPS6/DPS7 strap sampler: synchronizes, debounces and latches the JTAG/SPI
// select and boot strap, falling back to SPI/boot=0 on debounce timeout.
// Optional feature macro: DPS_STRAP_RESAMPLE_EN (software re-sample via WAIT_IDLE).
module dps_strap_ctrl
    import dps_strap_pkg::*;
#(
    parameter int unsigned DebounceCycles = 16,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strap_jtag_spi_n_i,
    input  logic strap_boot_i,
    input  logic spi_csb_i,
    input  logic jtag_trst_n_i,
    input  logic resample_req_i,
    output logic jtag_sel_o,
    output logic boot_strap_o,
    output logic strap_valid_o,
    output logic strap_err_o,
    output logic resample_ack_o
);

    localparam int unsigned StableW  = $clog2(DebounceCycles + 1);
    localparam int unsigned TimeoutW = $clog2(TimeoutCycles + 1);

    logic                sync_jtag, sync_boot;
    strap_t              strap_sync;
    state_e              state_q, state_d;
    strap_t              capture_q, capture_d;
    strap_t              strap_q, strap_d;
    logic [StableW-1:0]  stable_q, stable_d, stable_inc;
    logic [TimeoutW-1:0] timeout_q, timeout_d, timeout_inc;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                match, stable_done, timeout_done, start_debounce;
`ifdef DPS_STRAP_RESAMPLE_EN
    logic                ack_q, ack_d;
    logic                resample_q, resample_d;
`endif

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_sync_jtag (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (strap_jtag_spi_n_i),
        .q_o    (sync_jtag)
    );

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_sync_boot (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (strap_boot_i),
        .q_o    (sync_boot)
    );

    assign strap_sync = '{jtag_spi_n: sync_jtag, boot: sync_boot};

    // Saturating counter increments and the lock/timeout conditions they produce.
    always_comb begin
        stable_inc   = (stable_q == '1) ? stable_q : stable_q + 1'b1;
        timeout_inc  = (timeout_q == '1) ? timeout_q : timeout_q + 1'b1;
        match        = (strap_sync == capture_q);
        stable_done  = (state_q == StDebounce) && match
                       && (stable_inc == StableW'(DebounceCycles));
        timeout_done = (state_q == StDebounce) && (timeout_inc == TimeoutW'(TimeoutCycles));
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start_debounce marks entry into DEBOUNCE from IDLE or WAIT_IDLE.
    always_comb begin
        state_d        = state_q;
        start_debounce = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d        = StDebounce;
                start_debounce = 1'b1;
            end
            StDebounce: begin
                if (stable_done || timeout_done) begin
                    state_d = StLocked;
                end
            end
            StLocked: begin
`ifdef DPS_STRAP_RESAMPLE_EN
                if (resample_req_i) begin
                    state_d = StWaitIdle;
                end
`else
                state_d = StLocked;
`endif
            end
`ifdef DPS_STRAP_RESAMPLE_EN
            StWaitIdle: begin
                // Only swap the pad mux while both SPI and JTAG are idle.
                if (spi_csb_i && !jtag_trst_n_i) begin
                    state_d        = StDebounce;
                    start_debounce = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next-state: capture/counters while debouncing, latch on lock.
    always_comb begin
        capture_d = capture_q;
        stable_d  = stable_q;
        timeout_d = timeout_q;
        strap_d   = strap_q;
        valid_d   = valid_q;
        err_d     = err_q;
`ifdef DPS_STRAP_RESAMPLE_EN
        ack_d      = 1'b0;
        resample_d = resample_q;
`endif
        if (start_debounce) begin
            capture_d = strap_sync;
            stable_d  = '0;
            timeout_d = '0;
            valid_d   = 1'b0;
`ifdef DPS_STRAP_RESAMPLE_EN
            resample_d = (state_q == StWaitIdle);
`endif
        end else if (state_q == StDebounce) begin
            // Timeout keeps counting across mismatches so a noisy pad cannot stall forever.
            timeout_d = timeout_inc;
            if (match) begin
                stable_d = stable_inc;
            end else begin
                capture_d = strap_sync;
                stable_d  = '0;
            end
            if (stable_done) begin
                strap_d = capture_q;
                valid_d = 1'b1;
`ifdef DPS_STRAP_RESAMPLE_EN
                ack_d = resample_q;
`endif
            end else if (timeout_done) begin
                strap_d = StrapFallback;
                valid_d = 1'b1;
                err_d   = 1'b1;
`ifdef DPS_STRAP_RESAMPLE_EN
                ack_d = resample_q;
`endif
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            capture_q <= '0;
            stable_q  <= '0;
            timeout_q <= '0;
            strap_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef DPS_STRAP_RESAMPLE_EN
            ack_q      <= 1'b0;
            resample_q <= 1'b0;
`endif
        end else begin
            capture_q <= capture_d;
            stable_q  <= stable_d;
            timeout_q <= timeout_d;
            strap_q   <= strap_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
`ifdef DPS_STRAP_RESAMPLE_EN
            ack_q      <= ack_d;
            resample_q <= resample_d;
`endif
        end
    end

    assign jtag_sel_o    = strap_q.jtag_spi_n;
    assign boot_strap_o  = strap_q.boot;
    assign strap_valid_o = valid_q;
    assign strap_err_o   = err_q;

`ifdef DPS_STRAP_RESAMPLE_EN
    assign resample_ack_o = ack_q;
`else
    logic unused_resample_inputs;
    assign unused_resample_inputs = ^{resample_req_i, spi_csb_i, jtag_trst_n_i};
    assign resample_ack_o         = 1'b0;
`endif

endmodule

// File: tb/tb_dps_strap_ctrl.sv
// Scoreboard bench for dps_strap_ctrl: pad sequences are planned ahead, a run-length
// reference model predicts each lock outcome, and a monitor compares on valid rising.
module tb_dps_strap_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned T = 64;
    localparam int HistLen = 16384;

    logic clk_i              = 1'b0;
    logic rst_ni             = 1'b0;
    logic strap_jtag_spi_n_i = 1'b0;
    logic strap_boot_i       = 1'b0;
    logic spi_csb_i          = 1'b1;
    logic jtag_trst_n_i      = 1'b0;
    logic resample_req_i     = 1'b0;
    logic jtag_sel_o, boot_strap_o, strap_valid_o, strap_err_o, resample_ack_o;

    typedef struct {
        bit jtag;
        bit boot;
        bit err;
        bit ack;
        int lock_cyc;
    } exp_t;

    exp_t     exp_q[$];
    int       checks     = 0;
    int       errors     = 0;
    int       cyc        = 0;
    int       rel        = 0;
    bit       sticky_err = 1'b0;
    bit       cur_jtag   = 1'b0;
    bit       cur_boot   = 1'b0;
    bit       valid_prev = 1'b0;
    bit [1:0] pad_hist [HistLen];

    dps_strap_ctrl #(
        .DebounceCycles (D),
        .TimeoutCycles  (T)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .strap_jtag_spi_n_i (strap_jtag_spi_n_i),
        .strap_boot_i       (strap_boot_i),
        .spi_csb_i          (spi_csb_i),
        .jtag_trst_n_i      (jtag_trst_n_i),
        .resample_req_i     (resample_req_i),
        .jtag_sel_o         (jtag_sel_o),
        .boot_strap_o       (boot_strap_o),
        .strap_valid_o      (strap_valid_o),
        .strap_err_o        (strap_err_o),
        .resample_ack_o     (resample_ack_o)
    );

    always #5 clk_i = ~clk_i;

    // cyc == k after the k-th rising edge.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Pads follow the planned history; pad_hist[k] is the value presented to edge k.
    always @(posedge clk_i) begin
        #2;
        {strap_jtag_spi_n_i, strap_boot_i} = pad_hist[(cyc + 1) % HistLen];
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Strap pair visible to the debouncer at edge e (2-flop latency, 0 before release).
    function automatic bit [1:0] sync_at(input int e);
        if (e - 2 < rel) return 2'b00;
        return pad_hist[(e - 2) % HistLen];
    endfunction

    // Debounce entered at edge e: the first run of D+1 identical samples (counting the
    // one captured on entry) within T cycles wins, otherwise fall back with error.
    function automatic exp_t predict(input int e, input bit ack);
        exp_t     r;
        bit [1:0] c;
        int       run;
        c          = sync_at(e);
        run        = 1;
        r.ack      = ack;
        r.err      = 1'b1;
        r.jtag     = 1'b0;
        r.boot     = 1'b0;
        r.lock_cyc = e + T;
        for (int n = 1; n <= T; n++) begin
            if (sync_at(e + n) == c) begin
                run++;
            end else begin
                c   = sync_at(e + n);
                run = 1;
            end
            if (run == D + 1) begin
                r.err      = 1'b0;
                r.jtag     = c[1];
                r.boot     = c[0];
                r.lock_cyc = e + n;
                return r;
            end
        end
        return r;
    endfunction

    // kind 0 stable, 1 DPS6 toggling every 3 cycles, 2 two-cycle DPS6 glitch, else random.
    task automatic fill(input int start, input int len, input int kind, input bit [1:0] base,
                        input int pct);
        bit [1:0] v;
        v = base;
        for (int i = 0; i < len; i++) begin
            case (kind)
                0: v = base;
                1: v = {base[1] ^ bit'((i / 3) % 2), base[0]};
                2: v = (i == 3 || i == 4) ? {~base[1], base[0]} : base;
                default: if (int'($urandom_range(99)) < pct) v[$urandom_range(1)] ^= 1'b1;
            endcase
            pad_hist[(start + i) % HistLen] = v;
        end
    endtask

    task automatic push_expect(input int e, input bit ack);
        exp_t x;
        x          = predict(e, ack);
        x.err      = x.err | sticky_err;
        sticky_err = x.err;
        cur_jtag   = x.jtag;
        cur_boot   = x.boot;
        exp_q.push_back(x);
    endtask

    // Called at a negedge; asserts reset asynchronously and checks outputs right away.
    task automatic apply_reset();
        #2 rst_ni = 1'b0;
        #1;
        check("rst jtag_sel", jtag_sel_o, 0);
        check("rst boot_strap", boot_strap_o, 0);
        check("rst valid", strap_valid_o, 0);
        check("rst err", strap_err_o, 0);
        check("rst ack", resample_ack_o, 0);
        exp_q.delete();
        sticky_err = 1'b0;
        cur_jtag   = 1'b0;
        cur_boot   = 1'b0;
        @(negedge clk_i);
    endtask

    // Called at a negedge with reset low; releases reset so edge cyc+2 is the first active.
    task automatic start_from_reset(input int kind, input bit [1:0] base, input int pct);
        int r;
        r = cyc + 2;
        fill(r, T + 16, kind, base, pct);
        rel = r;
        push_expect(r, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk_i);
        end
        if (exp_q.size() != 0) begin
            check(name, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

`ifdef DPS_STRAP_RESAMPLE_EN
    task automatic resample_episode(input int kind, input bit [1:0] base, input int pct);
        int e;
        spi_csb_i      = 1'b0;
        jtag_trst_n_i  = 1'b1;
        resample_req_i = 1'b1;
        @(negedge clk_i);
        resample_req_i = 1'b0;
        fill(cyc + 2, 16, 3, 2'b00, 50);
        repeat (10) @(negedge clk_i);
        check("wait valid held", strap_valid_o, 1);
        check("wait jtag held", jtag_sel_o, cur_jtag);
        check("wait boot held", boot_strap_o, cur_boot);
        spi_csb_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("wait csb-only held", strap_valid_o, 1);
        e = cyc + 3;
        fill(cyc + 2, T + 16, kind, base, pct);
        push_expect(e, 1'b1);
        repeat (2) @(negedge clk_i);
        jtag_trst_n_i = 1'b0;
        @(negedge clk_i);
        resample_req_i = 1'b1;
        @(negedge clk_i);
        resample_req_i = 1'b0;
    endtask
`endif

    // Monitor: each rising strap_valid_o consumes one expectation; acks elsewhere are stray.
    always @(negedge clk_i) begin
        exp_t x;
        if (strap_valid_o && !valid_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected valid", 1, 0);
            end else begin
                x = exp_q.pop_front();
                check("lock jtag_sel", jtag_sel_o, x.jtag);
                check("lock boot_strap", boot_strap_o, x.boot);
                check("lock err", strap_err_o, x.err);
                check("lock ack", resample_ack_o, x.ack);
                check("lock cycle", cyc, x.lock_cyc);
            end
        end else if (resample_ack_o) begin
            check("stray ack", 1, 0);
        end
        valid_prev <= strap_valid_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        @(negedge clk_i);
        apply_reset();

        // Straps 11 held from reset: valid within D+4 cycles.
        start_from_reset(0, 2'b11, 0);
        wait_done(D + 4, "stable lock timeout");
        check("stable valid", strap_valid_o, 1);
        check("stable jtag_sel", jtag_sel_o, 1);
        check("stable boot", boot_strap_o, 1);
        check("stable err", strap_err_o, 0);

        // Locked outputs ignore pad activity.
        fill(cyc + 2, 30, 3, 2'b00, 60);
        repeat (20) @(negedge clk_i);
        check("hold jtag_sel", jtag_sel_o, 1);
        check("hold boot", boot_strap_o, 1);
        check("hold valid", strap_valid_o, 1);

        // DPS6 toggling every 3 cycles never settles: timeout fallback.
        apply_reset();
        start_from_reset(1, 2'b10, 0);
        wait_done(T + 10, "timeout lock timeout");
        fill(cyc + 2, 20, 3, 2'b11, 40);
        repeat (10) @(negedge clk_i);
        check("sticky err", strap_err_o, 1);
        check("fallback jtag_sel", jtag_sel_o, 0);
        check("fallback valid", strap_valid_o, 1);

        // Two-cycle glitch restarts the stable count.
        apply_reset();
        start_from_reset(2, 2'b11, 0);
        wait_done(T + 10, "glitch lock timeout");
        check("glitch final jtag_sel", jtag_sel_o, 1);

        // Random pad noise at increasing rates.
        for (int k = 0; k < 6; k++) begin
            apply_reset();
            start_from_reset(3, 2'($urandom), k * 12);
            wait_done(T + 10, "random lock timeout");
        end

        // Reset in the middle of debounce, then a clean restart.
        apply_reset();
        start_from_reset(0, 2'b11, 0);
        repeat (4) @(negedge clk_i);
        apply_reset();
        start_from_reset(0, 2'b01, 0);
        wait_done(D + 4, "restart lock timeout");
        check("restart jtag_sel", jtag_sel_o, 0);
        check("restart boot", boot_strap_o, 1);

`ifdef DPS_STRAP_RESAMPLE_EN
        resample_episode(0, 2'b10, 0);
        wait_done(T + 10, "resample lock timeout");
        check("resample jtag_sel", jtag_sel_o, 1);
        resample_episode(3, 2'($urandom), 10);
        wait_done(T + 10, "resample rand timeout");
        resample_episode(1, 2'b11, 0);
        wait_done(T + 10, "resample timeout timeout");
        repeat (3) @(negedge clk_i);
`else
        // Request while LOCKED with both interfaces idle must be ignored.
        spi_csb_i     = 1'b1;
        jtag_trst_n_i = 1'b0;
        fill(cyc + 2, 24, 0, 2'b10, 0);
        resample_req_i = 1'b1;
        @(negedge clk_i);
        resample_req_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            check("no ack", resample_ack_o, 0);
        end
        check("req ignored valid", strap_valid_o, 1);
        check("req ignored jtag_sel", jtag_sel_o, 0);
        check("req ignored boot", boot_strap_o, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dps_strap_ctrl.md
DPS_STRAP_CTRL -- requirements
Module: dps_strap_ctrl

Interface
REQ-001 The block SHALL have parameter DebounceCycles, default 16, giving the consecutive stable cycles required to accept strap values (legal range 2..255).
REQ-002 The block SHALL have parameter TimeoutCycles, default 1024, giving the maximum cycles spent debouncing before falling back (must be greater than DebounceCycles).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port strap_jtag_spi_n_i, input, 1 bit: raw DPS6 pad value, asynchronous to clk_i.
REQ-006 The block SHALL have port strap_boot_i, input, 1 bit: raw DPS7 pad value, asynchronous to clk_i.
REQ-007 The block SHALL have port spi_csb_i, input, 1 bit: SPI device chip select, high meaning idle.
REQ-008 The block SHALL have port jtag_trst_n_i, input, 1 bit: JTAG TRST_N, low meaning idle.
REQ-009 The block SHALL have port resample_req_i, input, 1 bit: single-cycle software request to re-sample the straps.
REQ-010 The block SHALL have port jtag_sel_o, output, 1 bit: mux select for the DPS pads, 1 = JTAG, 0 = SPI.
REQ-011 The block SHALL have port boot_strap_o, output, 1 bit: latched boot strap.
REQ-012 The block SHALL have port strap_valid_o, output, 1 bit: high while the latched straps are valid.
REQ-013 The block SHALL have port strap_err_o, output, 1 bit: sticky flag, set when debounce times out.
REQ-014 The block SHALL have port resample_ack_o, output, 1 bit: one-cycle pulse when a re-sample completes.

Function
REQ-015 Both strap inputs SHALL pass through 2-flop synchronizers with reset value 0; only the synchronized values SHALL be used by the block.
REQ-016 The state machine SHALL have the states IDLE, DEBOUNCE, LOCKED and WAIT_IDLE.
REQ-017 IDLE SHALL move to DEBOUNCE one cycle after reset release, clearing the stable counter and the timeout counter and loading the capture register from the synchronized straps.
REQ-018 In DEBOUNCE, when the synchronized straps equal the capture register the stable counter SHALL increment; otherwise the capture register SHALL reload and the stable counter SHALL clear.
REQ-019 In DEBOUNCE, the timeout counter SHALL increment every cycle and SHALL NOT be cleared by a mismatch.
REQ-020 When the stable counter reaches DebounceCycles, the block SHALL register the capture value to jtag_sel_o and boot_strap_o, set strap_valid_o on the next cycle and go to LOCKED.
REQ-021 When the timeout counter reaches TimeoutCycles before the stable counter reaches DebounceCycles, the block SHALL force jtag_sel_o=0 and boot_strap_o=0, set strap_err_o and strap_valid_o, and go to LOCKED.
REQ-022 If the stable and timeout conditions are reached in the same cycle, the stable result SHALL win and strap_err_o SHALL NOT be set.
REQ-023 In LOCKED, jtag_sel_o and boot_strap_o SHALL hold regardless of pad activity.
REQ-024 Both counters SHALL saturate and never wrap.
REQ-025 If the straps are stable from reset, strap_valid_o SHALL assert no later than DebounceCycles+4 cycles after reset release.

Reset
REQ-026 While rst_ni is low, the state SHALL be IDLE and jtag_sel_o, boot_strap_o, strap_valid_o, resample_ack_o and both synchronizers SHALL be 0.
REQ-027 strap_err_o SHALL reset to 0 and clear only on reset.
REQ-028 Reset asserted in any state SHALL abandon that state immediately, including in the middle of debounce or a re-sample.

Configuration
REQ-029 When DPS_STRAP_RESAMPLE_EN is defined, resample_req_i received in LOCKED SHALL move the block to WAIT_IDLE.
REQ-030 When DPS_STRAP_RESAMPLE_EN is defined, WAIT_IDLE SHALL hold the current outputs and valid until spi_csb_i=1 and jtag_trst_n_i=0 in the same cycle, then enter DEBOUNCE with strap_valid_o deasserted.
REQ-031 When DPS_STRAP_RESAMPLE_EN is defined, resample_ack_o SHALL pulse for one cycle on the cycle in which strap_valid_o reasserts.
REQ-032 When DPS_STRAP_RESAMPLE_EN is defined, resample_req_i received in any state other than LOCKED SHALL be ignored.
REQ-033 When DPS_STRAP_RESAMPLE_EN is not defined, resample_req_i SHALL be unused, resample_ack_o SHALL be tied to 0, the WAIT_IDLE state SHALL be absent, and LOCKED SHALL be left only through reset.

Structure
REQ-034 Package dps_strap_pkg SHALL hold the state enum type, a strap_t struct (jtag_spi_n, boot) and the default fallback strap_t constant.
REQ-035 The synchronizer SHALL be sub-module prim_flop_2sync, instanced twice; the state machine and counters SHALL stay in dps_strap_ctrl.

Verification
REQ-036 With DebounceCycles=4, DPS6=1 and DPS7=1 held from reset, the bench SHALL see jtag_sel_o=1, boot_strap_o=1 and strap_valid_o=1 within 8 cycles, and strap_err_o=0.
REQ-037 With DPS6 toggling every 3 cycles, TimeoutCycles=64 and DebounceCycles=4, the bench SHALL see strap_err_o=1, jtag_sel_o=0 and strap_valid_o=1 at cycle 64 plus synchronizer latency.
REQ-038 With a 2-cycle glitch on DPS6 during debounce, the bench SHALL see the stable counter restart and the final value equal to the post-glitch level.
REQ-039 With the macro on, after LOCKED with jtag_sel_o=0, a request while spi_csb_i=0 SHALL hold the outputs; csb released with DPS6=1 SHALL give jtag_sel_o=1 and a single resample_ack_o pulse.
REQ-040 With the macro off, a request while LOCKED SHALL leave the outputs unchanged and resample_ack_o SHALL never assert.
REQ-041 With rst_ni asserted mid-debounce, the bench SHALL see all outputs at 0 immediately, and debounce SHALL restart after release.
